// File: rtl/ieee754_pkg.sv
// rtl/ieee754_pkg.sv - shared types and constants for the float32 normalizer
// Contents: state_t (IDLE/NORM/DONE), field widths EXP_W/MNT_W/FRAC_W,
// exponent limits EXP_MAX and EXP_MIN_NORM.
package ieee754_pkg;

    localparam int EXP_W  = 8;
    localparam int MNT_W  = 25;
    localparam int FRAC_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_MIN_NORM = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ieee754_lzc.sv
// rtl/ieee754_lzc.sv - 24-bit combinational leading-zero counter
// Ports: din  [23:0] value to scan from bit 23 downward
//        cnt  [4:0]  number of leading zeros (24 when din is zero)
module ieee754_lzc (
    input  logic [23:0] din,
    output logic [4:0]  cnt
);

    // Scanning upward lets the highest set bit be the last one written.
    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (din[i]) begin
                cnt = 5'(23 - i);
            end
        end
    end

endmodule

// File: rtl/ieee754_norm.sv
// rtl/ieee754_norm.sv - normalizes {sign, exp, 25-bit mantissa} into a float32 word
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready handshake with in_sign, in_exp[7:0], in_mnt[24:0]
//        ([24] carry, [23] hidden bit, [22:0] fraction)
//        out_valid/out_ready handshake with out[31:0] = {sign, exp, frac}
// Option: IEEE754_NORM_FAST_EN replaces the one-bit-per-cycle left shift with a
//         single leading-zero shift (results unchanged, latency shorter).
module ieee754_norm
    import ieee754_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MNT_W-1:0]  in_mnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out
);

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [MNT_W-1:0]   mnt_q, mnt_d;
    logic [31:0]        out_q, out_d;
    logic [EXP_W-1:0]   exp_inc;

    assign exp_inc = exp_q + 8'd1;

`ifdef IEEE754_NORM_FAST_EN
    logic [4:0]         lz_cnt;
    logic [EXP_W-1:0]   lz_exp;
    logic [EXP_W-1:0]   exp_room;
    logic [23:0]        mnt_full;
    logic [MNT_W-1:0]   mnt_clamp;

    ieee754_lzc u_lzc (
        .din (mnt_q[23:0]),
        .cnt (lz_cnt)
    );

    // exp_room is how far the exponent may drop before reaching the minimum
    // normal exponent; a shift larger than that must stop there and flush.
    assign lz_exp    = {3'b000, lz_cnt};
    assign exp_room  = exp_q - EXP_MIN_NORM;
    assign mnt_full  = mnt_q[23:0] << lz_cnt;
    assign mnt_clamp = mnt_q << exp_room;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mnt_q   <= mnt_d;
            out_q   <= out_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mnt_d   = mnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mnt_d   = in_mnt;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mnt_q == '0 || exp_q == '0) begin
                    out_d   = {sign_q, 31'b0};
                    state_d = DONE;
                end else if (mnt_q[24]) begin
                    // Carry out: one right shift, truncating bit 0.
                    mnt_d   = mnt_q >> 1;
                    exp_d   = exp_inc;
                    out_d   = (exp_inc == EXP_MAX) ? {sign_q, EXP_MAX, 23'b0}
                                                   : {sign_q, exp_inc, mnt_q[23:1]};
                    state_d = DONE;
                end else if (mnt_q[23]) begin
                    out_d   = {sign_q, exp_q, mnt_q[FRAC_W-1:0]};
                    state_d = DONE;
                end else if (exp_q == EXP_MIN_NORM) begin
                    out_d   = {sign_q, 31'b0};
                    state_d = DONE;
                end else begin
`ifdef IEEE754_NORM_FAST_EN
                    if (lz_exp <= exp_room) begin
                        mnt_d   = {1'b0, mnt_full};
                        exp_d   = exp_q - lz_exp;
                        out_d   = {sign_q, exp_q - lz_exp, mnt_full[FRAC_W-1:0]};
                        state_d = DONE;
                    end else begin
                        // Exponent bottoms out first; the next edge flushes.
                        mnt_d = mnt_clamp;
                        exp_d = EXP_MIN_NORM;
                    end
`else
                    mnt_d = mnt_q << 1;
                    exp_d = exp_q - 8'd1;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        out       = out_q;
    end

endmodule

// File: tb/tb_ieee754_norm.sv
// tb/tb_ieee754_norm.sv - self-checking bench for ieee754_norm
module tb_ieee754_norm;

`ifdef IEEE754_NORM_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mnt;
    logic        out_valid, out_ready;
    logic [31:0] out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ieee754_norm dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mnt    (in_mnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [31:0] res;
        int          lat_ser;
        int          lat_fast;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Reference: locate the leading one and derive result and latency directly.
    function automatic void ref_model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                      output logic [31:0] r, output int lat);
        int p;
        int lz;
        logic [7:0]  ne;
        logic [24:0] sh;
        lat = 1;
        if (m == 0 || e == 0) begin
            r = {s, 31'b0};
        end else if (m[24]) begin
            ne = e + 8'd1;
            r  = (ne == 8'hFF) ? {s, 8'hFF, 23'b0} : {s, ne, m[23:1]};
        end else begin
            p = -1;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            lz = 23 - p;
            if (lz == 0) begin
                r = {s, e, m[22:0]};
            end else if (lz <= int'(e) - 1) begin
                sh  = m << lz;
                r   = {s, 8'(int'(e) - lz), sh[22:0]};
                lat = FAST ? 1 : 1 + lz;
            end else begin
                r   = {s, 31'b0};
                lat = (e == 8'd1) ? 1 : (FAST ? 2 : int'(e));
            end
        end
    endfunction

    // Presents an operand; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic s, input logic [7:0] e, input logic [24:0] m, input string nm);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mnt   = m;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                          input logic [31:0] want, input int want_lat, input string nm);
        int lat;
        start_op(s, e, m, nm);
        wait_done(lat);
        chk({nm, "_out"}, out, want);
        chk({nm, "_lat"}, 32'(lat), 32'(want_lat));
        release_out(nm);
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        logic        rs;
        logic [7:0]  re;
        logic [24:0] rm;

        vt[0]  = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1,  1};
        vt[1]  = '{1'b0, 8'h7F, 25'h1000000, 32'h40000000, 1,  1};
        vt[2]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1,  1};
        vt[3]  = '{1'b0, 8'h7F, 25'h0200000, 32'h3E800000, 3,  1};
        vt[4]  = '{1'b1, 8'h02, 25'h0100000, 32'h80000000, 2,  2};
        vt[5]  = '{1'b1, 8'h00, 25'h0800000, 32'h80000000, 1,  1};
        vt[6]  = '{1'b0, 8'h55, 25'h0000000, 32'h00000000, 1,  1};
        vt[7]  = '{1'b1, 8'hFF, 25'h1000003, 32'h80000001, 1,  1};
        vt[8]  = '{1'b0, 8'hFF, 25'h0FFFFFF, 32'h7FFFFFFF, 1,  1};
        vt[9]  = '{1'b0, 8'h01, 25'h0000001, 32'h00000000, 1,  1};
        vt[10] = '{1'b0, 8'h18, 25'h0000001, 32'h00800000, 24, 1};
        vt[11] = '{1'b1, 8'h81, 25'h1FFFFFF, 32'hC17FFFFF, 1,  1};
        vt[12] = '{1'b0, 8'h17, 25'h0000001, 32'h00000000, 23, 2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mnt    = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].s, vt[i].e, vt[i].m, vt[i].res,
                   FAST ? vt[i].lat_fast : vt[i].lat_ser, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       re = 8'($urandom);
                1:       re = 8'($urandom_range(0, 3));
                2:       re = 8'($urandom_range(252, 255));
                default: re = 8'($urandom_range(1, 30));
            endcase
            rm = 25'($urandom) >> $urandom_range(0, 24);
            ref_model(rs, re, rm, r, lat);
            run_op(rs, re, rm, r, lat, $sformatf("rnd%0d", i));
        end

        // Back-pressure: result held while out_ready is low, new operands ignored.
        start_op(1'b0, 8'h7F, 25'h0800000, "bp");
        wait_done(lat);
        chk("bp_out", out, 32'h3F800000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_exp   = 8'h10;
            in_mnt   = 25'h0000001;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold%0d_out", i), out, 32'h3F800000);
            chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out("bp");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_noqueue%0d", i), 32'(out_valid), 32'd0);
        end

        // Reset in the middle of normalization.
        start_op(1'b0, 8'h17, 25'h0000001, "mid");
        in_valid = 1'b1;
        in_exp   = 8'h7F;
        in_mnt   = 25'h0800000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_busy_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", out, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mid_squashed%0d", i), 32'(out_valid), 32'd0);
        end
        run_op(vt[3].s, vt[3].e, vt[3].m, vt[3].res,
               FAST ? vt[3].lat_fast : vt[3].lat_ser, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ieee754_norm.md
IEEE754_NORM -- requirements
Module: ieee754_norm

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, raw operand present.
REQ-004 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-005 SHALL have port in_sign, input, 1, result sign.
REQ-006 SHALL have port in_exp, input, 8, biased exponent.
REQ-007 SHALL have port in_mnt, input, 25, unnormalized mantissa: [24] carry, [23] hidden bit, [22:0] fraction.
REQ-008 SHALL have port out_valid, output, 1, normalized result present.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-010 SHALL have port out, output, 32, float32 result {sign, exp[7:0], frac[22:0]}.

Function
REQ-011 SHALL implement FSM IDLE -> NORM -> DONE -> IDLE; in_ready = 1 only in IDLE with rst low.
REQ-012 SHALL accept on an edge with in_valid & in_ready: register sign/exp/mnt, go to NORM.
REQ-013 Each NORM edge SHALL apply the first matching rule:
- (a) mnt == 0 or exp == 0 -> signed zero {sign, 31'b0}, DONE.
- (b) mnt[24] -> mnt >>= 1 (bit 0 truncated), exp += 1; exp becomes 0xFF -> signed infinity {sign, 0xFF, 23'b0}; DONE.
- (c) mnt[23] -> DONE.
- (d) exp == 1 -> flush to signed zero, DONE.
- (e) otherwise mnt <<= 1, exp -= 1, stay in NORM.
REQ-014 Latency SHALL be: DONE entered on edge E(1+k) after the accepting edge E0, where k = number of left shifts (0..23); rules (a), (b), (c) give k = 0.
REQ-015 In DONE, out_valid SHALL be 1 and out SHALL hold stable until an edge with out_ready = 1, which returns the FSM to IDLE.
REQ-016 in_valid asserted outside IDLE SHALL be ignored; no operand is queued.
REQ-017 Operand fields SHALL not be checked for NaN/inf inputs; in_exp = 0xFF follows rules (a)-(e) literally.

Reset
REQ-018 rst SHALL immediately force state IDLE, out_valid = 0, out = 0 and internal registers = 0, including mid-NORM or mid-DONE.
REQ-019 in_ready SHALL be 0 while rst is high and 1 on the first clock after release.

Configuration
REQ-020 With IEEE754_NORM_FAST_EN defined, rule (e) SHALL apply the full leading-zero shift in one NORM edge, clamped so exp never goes below 1 (clamp hits 1 before mnt[23] set -> rule (d) on the next edge). k is always 0 except in that clamp case, where it is 1.
REQ-021 Without IEEE754_NORM_FAST_EN, rule (e) SHALL shift bit-serially as in REQ-013. Results SHALL be identical in both modes; only latency differs.

Structure
REQ-022 Package ieee754_pkg SHALL hold:
- state enum (IDLE/NORM/DONE)
- EXP_W = 8, MNT_W = 25, FRAC_W = 23
- constants EXP_MAX = 8'hFF, EXP_MIN_NORM = 8'h01
REQ-023 Sub-module ieee754_lzc (24-bit leading-zero count, combinational) SHALL be instantiated only under IEEE754_NORM_FAST_EN.

Verification
REQ-024 Normalized input: exp = 0x7F, mnt = 0x0800000 -> out = 0x3F800000, out_valid after E1.
REQ-025 Carry input: exp = 0x7F, mnt = 0x1000000 -> out = 0x40000000 after E1; exp = 0xFE with the same mnt, sign = 0 -> out = 0x7F800000.
REQ-026 Left shifts: exp = 0x7F, mnt = 0x0200000 -> out = 0x3E800000, DONE at E3 (serial) or E1 (fast).
REQ-027 Underflow: sign = 1, exp = 0x02, mnt = 0x0100000 -> out = 0x80000000 (flush).
REQ-028 Back-pressure: out_ready low 5 cycles in DONE -> out stable, in_ready = 0, extra in_valid ignored; then rst pulsed mid-NORM -> out_valid = 0, out = 0, in_ready = 1 after release.
